// File: rtl/stream_demux_4.sv
// 1-to-4 valid/ready stream demux, one registered slot per output channel.
// Optional DEMUX_COUNT_EN adds per-channel 8-bit output handshake counters.
module stream_demux_4 #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [W-1:0]   in_data,
  input  logic [1:0]     in_sel,
  input  logic           in_valid,
  output logic           in_ready,
  output logic [4*W-1:0] out_data,
  output logic [3:0]     out_valid,
  input  logic [3:0]     out_ready,
  output logic [31:0]    out_count
);

  typedef enum logic {EMPTY, FULL} state_e;

  state_e         state_q [4];
  state_e         state_d [4];
  logic [W-1:0]   data_q  [4];
  logic [W-1:0]   data_d  [4];
  logic           accept;

  always_comb begin
    in_ready = !reset &&
      (state_q[in_sel] == EMPTY || out_ready[in_sel]);
    accept   = in_valid && in_ready;
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      state_d[i] = state_q[i];
      data_d[i]  = data_q[i];
      unique case (state_q[i])
        EMPTY: begin
          if (accept && in_sel == 2'(i)) begin
            state_d[i] = FULL;
            data_d[i]  = in_data;
          end
        end
        FULL: begin
          // a same-cycle load replaces the draining word
          if (accept && in_sel == 2'(i)) begin
            data_d[i] = in_data;
          end else if (out_ready[i]) begin
            state_d[i] = EMPTY;
          end
        end
        default: state_d[i] = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        state_q[i] <= EMPTY;
        data_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        state_q[i] <= state_d[i];
        data_q[i]  <= data_d[i];
      end
    end
  end

  always_comb begin
    out_data  = '0;
    out_valid = '0;
    for (int i = 0; i < 4; i++) begin
      out_data[i*W +: W] = data_q[i];
      out_valid[i]       = (state_q[i] == FULL);
    end
  end

`ifdef DEMUX_COUNT_EN
  logic [7:0] cnt_q [4];
  logic [7:0] cnt_d [4];

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = cnt_q[i];
      if (out_valid[i] && out_ready[i]) begin
        cnt_d[i] = cnt_q[i] + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign out_count = {cnt_q[3], cnt_q[2], cnt_q[1], cnt_q[0]};
`else
  assign out_count = 32'h0;
`endif

endmodule

// File: tb/tb_stream_demux_4.sv
// Directed self-checking bench for stream_demux_4.
// Expectations follow DEMUX_COUNT_EN when checking out_count.
module tb_stream_demux_4;

  localparam int W = 8;

  logic           clk;
  logic           reset;
  logic [W-1:0]   in_data;
  logic [1:0]     in_sel;
  logic           in_valid;
  logic           in_ready;
  logic [4*W-1:0] out_data;
  logic [3:0]     out_valid;
  logic [3:0]     out_ready;
  logic [31:0]    out_count;

  int nvec = 0;
  int nerr = 0;

  stream_demux_4 #(.W(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_count (out_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] ch(input int i);
    return out_data[i*W +: W];
  endfunction

  initial begin
    logic [31:0] exp_cnt;
    reset     = 1'b1;
    in_data   = '0;
    in_sel    = '0;
    in_valid  = 1'b0;
    out_ready = 4'h0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'h0);
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_data", out_data, 32'h0);
    chk("rst_count", out_count, 32'h0);
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("rel_in_ready", 32'(in_ready), 32'h1);

    // routing: one word per channel, one per cycle
    out_ready = 4'hF;
    for (int k = 0; k < 4; k++) begin
      in_sel   = 2'(k);
      in_data  = 8'hA0 + 8'(k);
      in_valid = 1'b1;
      #1;
      chk("route_in_ready", 32'(in_ready), 32'h1);
      tick();
      chk("route_valid", 32'(out_valid), 32'(4'b0001 << k));
      chk("route_data", 32'(ch(k)), 32'(8'hA0 + 8'(k)));
    end
    in_valid = 1'b0;
    tick();
    chk("route_drain", 32'(out_valid), 32'h0);

    // stall on ch1, ch3 still accepted
    out_ready = 4'b1101;
    in_sel    = 2'd1;
    in_data   = 8'h11;
    in_valid  = 1'b1;
    tick();
    chk("stall_v1", 32'(out_valid), 32'b0010);
    chk("stall_d1", 32'(ch(1)), 32'h11);
    in_data = 8'h22;
    #1;
    chk("stall_in_ready", 32'(in_ready), 32'h0);
    tick();
    chk("stall_hold", 32'(ch(1)), 32'h11);
    chk("stall_hold_v", 32'(out_valid), 32'b0010);
    in_sel  = 2'd3;
    in_data = 8'h33;
    #1;
    chk("stall_ch3_ready", 32'(in_ready), 32'h1);
    tick();
    chk("stall_both_v", 32'(out_valid), 32'b1010);
    chk("stall_ch3_d", 32'(ch(3)), 32'h33);
    chk("stall_ch1_d", 32'(ch(1)), 32'h11);
    in_valid  = 1'b0;
    out_ready = 4'hF;
    tick();
    chk("stall_drain", 32'(out_valid), 32'h0);

    // drain and refill ch0 in one cycle
    out_ready = 4'h0;
    in_sel    = 2'd0;
    in_data   = 8'h55;
    in_valid  = 1'b1;
    tick();
    chk("refill_first", 32'(ch(0)), 32'h55);
    out_ready = 4'b0001;
    in_data   = 8'h66;
    #1;
    chk("refill_in_ready", 32'(in_ready), 32'h1);
    tick();
    chk("refill_valid", 32'(out_valid), 32'b0001);
    chk("refill_data", 32'(ch(0)), 32'h66);
    in_valid  = 1'b0;
    out_ready = 4'h0;
    #1;
    chk("full_blocks", 32'(in_ready), 32'h0);

    // idle input with toggling sel/data
    for (int k = 0; k < 4; k++) begin
      in_sel  = 2'(k);
      in_data = 8'hC0 + 8'(k);
      tick();
      chk("idle_valid", 32'(out_valid), 32'b0001);
      chk("idle_data", 32'(ch(0)), 32'h66);
    end
    out_ready = 4'hF;
    tick();
    chk("idle_drain", 32'(out_valid), 32'h0);

    // reset mid-stream with ch2 full
    out_ready = 4'h0;
    in_sel    = 2'd2;
    in_data   = 8'h77;
    in_valid  = 1'b1;
    tick();
    chk("mid_full", 32'(out_valid), 32'b0100);
    in_valid = 1'b0;
    reset    = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'h0);
    chk("mid_rst_ready", 32'(in_ready), 32'h0);
    tick();
    reset  = 1'b0;
    in_sel = 2'd0;
    #1;
    chk("mid_rel_ready", 32'(in_ready), 32'h1);
    chk("mid_rel_count", out_count, 32'h0);

    // 257 handshakes on ch3
    out_ready = 4'hF;
    in_sel    = 2'd3;
    in_valid  = 1'b1;
    for (int k = 0; k < 257; k++) begin
      in_data = 8'(k);
      tick();
    end
    in_valid = 1'b0;
    tick();
    chk("cnt_empty", 32'(out_valid), 32'h0);
`ifdef DEMUX_COUNT_EN
    exp_cnt = 32'h0100_0000;
`else
    exp_cnt = 32'h0;
`endif
    chk("cnt_value", out_count, exp_cnt);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
